watchdog_supervisor: RTL and testbench

Sits between the AM radio datapath blocks and watchdog_timer. It combines per-source liveness pulses from N requesters (NCO, sample DMA, SCPI command handler, …) into the single heartbeat the watchdog expects, and drives the watchdog enable. When the watchdog fires force_reset, it sequences recovery: system reset hold, then a grace period, then re-arm. It counts faults and locks out after too many.

---
 rtl/watchdog_supervisor.sv | 130 +++++++++++++
 tb/tb_watchdog_supervisor.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/watchdog_supervisor.sv
// rtl/watchdog_supervisor.sv - merges per-source heartbeats for watchdog_timer and sequences fault recovery
// Recovery path: RUN -> RECOVER (sys_reset hold) -> GRACE (watchdog disabled) -> RUN/IDLE, LOCKOUT after MAX_FAULTS.
module watchdog_supervisor #(
  parameter int N_SRC        = 3,
  parameter int RESET_HOLD   = 16,
  parameter int GRACE_CYCLES = 1024,
  parameter int MAX_FAULTS   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src_hb,
  input  logic [N_SRC-1:0] src_mask,
  input  logic             arm,
  input  logic             clr_faults,
  input  logic             wd_force_reset,
  output logic             wd_enable,
  output logic             wd_heartbeat,
  output logic             sys_reset,
  output logic [N_SRC-1:0] missing,
  output logic [7:0]       fault_count,
  output logic             locked_out,
  output logic [2:0]       state
);

  localparam int HOLD_MAX = (RESET_HOLD > GRACE_CYCLES) ? RESET_HOLD : GRACE_CYCLES;
  localparam int CW       = $clog2(HOLD_MAX + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    RECOVER = 3'd2,
    GRACE   = 3'd3,
    LOCKOUT = 3'd4
  } state_t;

  state_t           cur, nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [N_SRC-1:0] pending, pending_nxt, acc, missing_nxt;
  logic [7:0]       fault_nxt, bumped;
  logic             hb_nxt, round_done;

  assign state = cur;

  always_comb begin
    nxt         = cur;
    cnt_nxt     = cnt;
    pending_nxt = pending;
    fault_nxt   = fault_count;
    hb_nxt      = 1'b0;
    acc         = pending | (src_hb & src_mask);
    round_done  = (src_mask != '0) && ((acc & src_mask) == src_mask);
    bumped      = (fault_count == 8'hFF) ? 8'hFF : fault_count + 8'd1;

    case (cur)
      IDLE: begin
        pending_nxt = '0;
        if (arm) nxt = RUN;
      end
      RUN: begin
        if (wd_force_reset) begin
          fault_nxt   = bumped;
          pending_nxt = '0;
          // A simultaneous clr_faults zeroes the count, so it can never trigger lockout.
          if (!clr_faults && (32'(bumped) >= 32'(MAX_FAULTS))) begin
            nxt = LOCKOUT;
          end else begin
            nxt     = RECOVER;
            cnt_nxt = CW'(RESET_HOLD - 1);
          end
        end else if (!arm) begin
          nxt         = IDLE;
          pending_nxt = '0;
        end else if (round_done) begin
          hb_nxt      = 1'b1;
          pending_nxt = '0;
        end else begin
          pending_nxt = acc;
        end
      end
      RECOVER: begin
        if (cnt == '0) begin
          nxt     = GRACE;
          cnt_nxt = CW'(GRACE_CYCLES - 1);
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      GRACE: begin
        if (cnt == '0) nxt = arm ? RUN : IDLE;
        else           cnt_nxt = cnt - 1'b1;
      end
      LOCKOUT: begin
        if (clr_faults) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase

    if (clr_faults) fault_nxt = 8'd0;

    // missing shows the round including this cycle's hits, so a completing round reads 0 for one cycle.
    if (nxt != RUN)      missing_nxt = '0;
    else if (cur == RUN) missing_nxt = src_mask & ~acc;
    else                 missing_nxt = src_mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur          <= IDLE;
      cnt          <= '0;
      pending      <= '0;
      fault_count  <= 8'd0;
      wd_enable    <= 1'b0;
      wd_heartbeat <= 1'b0;
      sys_reset    <= 1'b0;
      locked_out   <= 1'b0;
      missing      <= '0;
    end else begin
      cur          <= nxt;
      cnt          <= cnt_nxt;
      pending      <= pending_nxt;
      fault_count  <= fault_nxt;
      wd_enable    <= (nxt == RUN);
      wd_heartbeat <= hb_nxt;
      sys_reset    <= (nxt == RECOVER) || (nxt == LOCKOUT);
      locked_out   <= (nxt == LOCKOUT);
      missing      <= missing_nxt;
    end
  end

endmodule

// File: tb/tb_watchdog_supervisor.sv
// tb/tb_watchdog_supervisor.sv - directed self-checking bench for watchdog_supervisor
module tb_watchdog_supervisor;

  logic       clk = 1'b0;
  logic       rst, arm, clr_faults, wd_force_reset;
  logic [2:0] src_hb, src_mask;
  logic       wd_enable, wd_heartbeat, sys_reset, locked_out;
  logic [2:0] missing, state;
  logic [7:0] fault_count;

  int errors = 0;
  int checks = 0;
  int n;

  watchdog_supervisor #(
    .N_SRC(3), .RESET_HOLD(16), .GRACE_CYCLES(1024), .MAX_FAULTS(4)
  ) dut (
    .clk(clk), .rst(rst), .src_hb(src_hb), .src_mask(src_mask), .arm(arm),
    .clr_faults(clr_faults), .wd_force_reset(wd_force_reset),
    .wd_enable(wd_enable), .wd_heartbeat(wd_heartbeat), .sys_reset(sys_reset),
    .missing(missing), .fault_count(fault_count), .locked_out(locked_out),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] target, input int limit);
    int k = 0;
    while (state !== target && k < limit) begin
      tick();
      k++;
    end
    check("wait_state", {29'd0, state}, {29'd0, target});
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; clr_faults = 1'b0; wd_force_reset = 1'b0;
    src_hb = 3'b000; src_mask = 3'b000;
    tick(); tick();
    rst = 1'b0;
    check("rst_state", {29'd0, state}, 32'd0);
    check("rst_enable", {31'd0, wd_enable}, 32'd0);
    check("rst_sysreset", {31'd0, sys_reset}, 32'd0);
    check("rst_locked", {31'd0, locked_out}, 32'd0);
    check("rst_missing", {29'd0, missing}, 32'd0);
    check("rst_faults", {24'd0, fault_count}, 32'd0);
    check("rst_hb", {31'd0, wd_heartbeat}, 32'd0);

    // Round with all three sources required
    src_mask = 3'b111; arm = 1'b1;
    tick();
    check("t1_run", {29'd0, state}, 32'd1);
    check("t1_enable", {31'd0, wd_enable}, 32'd1);
    check("t1_missing0", {29'd0, missing}, 32'h7);
    tick(); tick(); tick();
    src_hb = 3'b001; tick(); src_hb = 3'b000;
    check("t1_missing1", {29'd0, missing}, 32'h6);
    tick(); tick();
    src_hb = 3'b010; tick(); src_hb = 3'b000;
    check("t1_missing2", {29'd0, missing}, 32'h4);
    check("t1_no_hb", {31'd0, wd_heartbeat}, 32'd0);
    tick(); tick(); tick();
    src_hb = 3'b100; tick(); src_hb = 3'b000;
    check("t1_hb", {31'd0, wd_heartbeat}, 32'd1);
    check("t1_missing3", {29'd0, missing}, 32'h0);
    tick();
    check("t1_hb_end", {31'd0, wd_heartbeat}, 32'd0);
    check("t1_missing4", {29'd0, missing}, 32'h7);

    // Unmasked source never completes a round
    src_mask = 3'b101;
    tick();
    for (int i = 0; i < 4; i++) begin
      src_hb = 3'b010; tick(); src_hb = 3'b000;
      check("t2_no_hb", {31'd0, wd_heartbeat}, 32'd0);
      check("t2_missing", {29'd0, missing}, 32'h5);
    end
    src_hb = 3'b101; tick(); src_hb = 3'b000;
    check("t2_hb", {31'd0, wd_heartbeat}, 32'd1);
    tick();
    check("t2_hb_end", {31'd0, wd_heartbeat}, 32'd0);

    // Full recovery sequence timing
    wd_force_reset = 1'b1; tick(); wd_force_reset = 1'b0;
    check("t3_recover", {29'd0, state}, 32'd2);
    check("t3_sysreset", {31'd0, sys_reset}, 32'd1);
    check("t3_faults", {24'd0, fault_count}, 32'd1);
    check("t3_enable_off", {31'd0, wd_enable}, 32'd0);
    n = 0;
    while (state === 3'd2 && n < 100) begin n++; tick(); end
    check("t3_hold_len", n, 32'd16);
    check("t3_grace", {29'd0, state}, 32'd3);
    check("t3_grace_sysreset", {31'd0, sys_reset}, 32'd0);
    check("t3_grace_enable", {31'd0, wd_enable}, 32'd0);
    n = 0;
    while (state === 3'd3 && n < 3000) begin n++; tick(); end
    check("t3_grace_len", n, 32'd1024);
    check("t3_rerun", {29'd0, state}, 32'd1);
    check("t3_rerun_enable", {31'd0, wd_enable}, 32'd1);

    // Lockout after MAX_FAULTS fires
    clr_faults = 1'b1; tick(); clr_faults = 1'b0;
    check("t4_clr_run", {24'd0, fault_count}, 32'd0);
    check("t4_clr_state", {29'd0, state}, 32'd1);
    for (int i = 1; i <= 3; i++) begin
      wd_force_reset = 1'b1; tick(); wd_force_reset = 1'b0;
      check("t4_count", {24'd0, fault_count}, i);
      check("t4_recover", {29'd0, state}, 32'd2);
      wait_state(3'd1, 2000);
    end
    wd_force_reset = 1'b1; tick(); wd_force_reset = 1'b0;
    check("t4_lockout", {29'd0, state}, 32'd4);
    check("t4_locked", {31'd0, locked_out}, 32'd1);
    check("t4_sysreset", {31'd0, sys_reset}, 32'd1);
    check("t4_count4", {24'd0, fault_count}, 32'd4);
    for (int i = 0; i < 5; i++) tick();
    check("t4_held", {29'd0, state}, 32'd4);
    check("t4_held_sysreset", {31'd0, sys_reset}, 32'd1);
    clr_faults = 1'b1; tick(); clr_faults = 1'b0;
    check("t4_exit_idle", {29'd0, state}, 32'd0);
    check("t4_exit_count", {24'd0, fault_count}, 32'd0);
    check("t4_exit_locked", {31'd0, locked_out}, 32'd0);
    check("t4_exit_sysreset", {31'd0, sys_reset}, 32'd0);

    // Fault beats disarm; fault ignored during GRACE
    tick();
    check("t5_run", {29'd0, state}, 32'd1);
    wd_force_reset = 1'b1; arm = 1'b0; tick(); wd_force_reset = 1'b0; arm = 1'b1;
    check("t5_prio_state", {29'd0, state}, 32'd2);
    check("t5_prio_count", {24'd0, fault_count}, 32'd1);
    wait_state(3'd3, 100);
    wd_force_reset = 1'b1; tick(); wd_force_reset = 1'b0;
    check("t5_grace_ignore", {29'd0, state}, 32'd3);
    check("t5_grace_count", {24'd0, fault_count}, 32'd1);
    wait_state(3'd1, 2000);

    // rst in the middle of RECOVER
    wd_force_reset = 1'b1; tick(); wd_force_reset = 1'b0;
    check("t6_count", {24'd0, fault_count}, 32'd2);
    for (int i = 0; i < 5; i++) tick();
    check("t6_mid", {29'd0, state}, 32'd2);
    rst = 1'b1; tick(); rst = 1'b0;
    check("t6_state", {29'd0, state}, 32'd0);
    check("t6_sysreset", {31'd0, sys_reset}, 32'd0);
    check("t6_count0", {24'd0, fault_count}, 32'd0);
    check("t6_enable", {31'd0, wd_enable}, 32'd0);

    // clr_faults coincident with a fault: count zero, still RECOVER
    tick();
    check("t7_run", {29'd0, state}, 32'd1);
    wd_force_reset = 1'b1; clr_faults = 1'b1; tick();
    wd_force_reset = 1'b0; clr_faults = 1'b0;
    check("t7_state", {29'd0, state}, 32'd2);
    check("t7_count", {24'd0, fault_count}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
